// File: rtl/parking_pkg.sv
// parking_pkg
// Shared definitions for the parking ticket issuer:
//   - state_t    : ticket FSM states
//   - SEG_*      : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - seg7()     : 0..9 and 'F' to segment pattern, anything else blanks
//   - lfsr_next(): one step of the 8-bit PIN LFSR (x^8 + x^6 + x^5 + x^4 + 1)
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd15:   seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Fibonacci form: feedback is the XOR of stages 8,6,5,4 shifted in at the bottom.
    // The map is invertible, so a nonzero state never reaches all-zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Two-flop synchronizer followed by a rising-edge detector on the
// polarity-corrected level.
//   clk, reset_n : system clock, synchronous active-low reset
//   i_async      : asynchronous input
//   o_pulse      : one-cycle pulse when the input becomes active
// ACTIVE_LOW = 1 treats a low input as active. Polarity is folded in before
// the first flop so that cleared flops always mean "inactive" and no pulse
// appears when reset is released.
module sync_edge #(
    parameter logic ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async ^ ACTIVE_LOW;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/parking_ticket_issuer.sv
// parking_ticket_issuer
// Entrance kiosk: on a ticket request (lot not full) draws a 2+2 bit PIN from
// an LFSR, presents it to the gate with pin_valid until ack or timeout, and
// tracks lot occupancy from gate acks and the exit sensor.
//   clk, reset_n           : 50 MHz clock, synchronous active-low reset
//   ticket_req_n           : raw push button, active low, asynchronous
//   sensor_exit            : exit-lane sensor, active high, asynchronous
//   ticket_ack             : one-cycle gate pulse, car entered on this ticket
//   pin_1, pin_2           : PIN digits to the gate
//   pin_valid              : PIN digits are a live ticket
//   lot_full, occupancy    : lot status
//   HEX_PIN1/HEX_PIN2/HEX_OCC : active-low segment drives {g,f,e,d,c,b,a}
// All outputs come straight from flops; the displays are registered in the
// same cycle as the values they show.
module parking_ticket_issuer
    import parking_pkg::*;
#(
    parameter int         CAPACITY    = 8,
    parameter int         HOLD_CYCLES = 500_000_000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ticket_req_n,
    input  logic       sensor_exit,
    input  logic       ticket_ack,
    output logic [1:0] pin_1,
    output logic [1:0] pin_2,
    output logic       pin_valid,
    output logic       lot_full,
    output logic [3:0] occupancy,
    output logic [6:0] HEX_PIN1,
    output logic [6:0] HEX_PIN2,
    output logic [6:0] HEX_OCC
);

    localparam logic [3:0]  CAP_VAL   = 4'(CAPACITY);
    localparam logic [28:0] HOLD_LAST = 29'(HOLD_CYCLES - 1);

    logic        w_req_pulse;
    logic        w_exit_pulse;
    logic        w_ack_ok;

    state_t      r_state;
    logic [7:0]  r_lfsr;
    logic [28:0] r_hold_cnt;
    logic [1:0]  r_pin_1;
    logic [1:0]  r_pin_2;
    logic        r_pin_valid;
    logic [3:0]  r_occupancy;
    logic        r_lot_full;
    logic [6:0]  r_hex_pin1;
    logic [6:0]  r_hex_pin2;
    logic [6:0]  r_hex_occ;

    state_t      w_state_nxt;
    logic [28:0] w_hold_nxt;
    logic [1:0]  w_pin_1_nxt;
    logic [1:0]  w_pin_2_nxt;
    logic        w_pin_valid_nxt;
    logic [3:0]  w_occ_nxt;
    logic        w_full_nxt;
    logic [6:0]  w_hex_pin1_nxt;
    logic [6:0]  w_hex_pin2_nxt;
    logic [6:0]  w_hex_occ_nxt;

    sync_edge #(.ACTIVE_LOW(1'b1)) u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (ticket_req_n),
        .o_pulse (w_req_pulse)
    );

    sync_edge #(.ACTIVE_LOW(1'b0)) u_exit_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (sensor_exit),
        .o_pulse (w_exit_pulse)
    );

    // Only an ack against a live ticket counts as an entry.
    assign w_ack_ok = (r_state == ST_WAIT_ACK) && ticket_ack;

    // Ticket FSM next state and PIN/hold-counter updates.
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold_cnt;
        w_pin_1_nxt     = r_pin_1;
        w_pin_2_nxt     = r_pin_2;
        w_pin_valid_nxt = r_pin_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_req_pulse && !r_lot_full) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_pin_1_nxt     = r_lfsr[1:0];
                w_pin_2_nxt     = r_lfsr[3:2];
                w_pin_valid_nxt = 1'b1;
                w_hold_nxt      = 29'd0;
                w_state_nxt     = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // Ack wins over a timeout landing in the same cycle.
                if (ticket_ack) begin
                    w_pin_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_pin_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt + 29'd1;
                end
            end
            default: begin
                w_pin_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // Occupancy with saturation; simultaneous entry and exit cancel out.
    always_comb begin
        w_occ_nxt = r_occupancy;
        if (w_ack_ok && !w_exit_pulse) begin
            if (r_occupancy != CAP_VAL) begin
                w_occ_nxt = r_occupancy + 4'd1;
            end else begin
                w_occ_nxt = r_occupancy;
            end
        end else if (w_exit_pulse && !w_ack_ok) begin
            if (r_occupancy != 4'd0) begin
                w_occ_nxt = r_occupancy - 4'd1;
            end else begin
                w_occ_nxt = r_occupancy;
            end
        end else begin
            w_occ_nxt = r_occupancy;
        end
        w_full_nxt = (w_occ_nxt == CAP_VAL);
    end

    // Display patterns derived from next-state values so they change with their sources.
    always_comb begin
        w_hex_pin1_nxt = w_pin_valid_nxt ? seg7({2'b00, w_pin_1_nxt}) : SEG_BLANK;
        w_hex_pin2_nxt = w_pin_valid_nxt ? seg7({2'b00, w_pin_2_nxt}) : SEG_BLANK;
        w_hex_occ_nxt  = w_full_nxt ? SEG_F : seg7(w_occ_nxt);
    end

    // State, LFSR and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_hold_cnt  <= 29'd0;
            r_pin_1     <= 2'd0;
            r_pin_2     <= 2'd0;
            r_pin_valid <= 1'b0;
            r_occupancy <= 4'd0;
            r_lot_full  <= 1'b0;
            r_hex_pin1  <= SEG_BLANK;
            r_hex_pin2  <= SEG_BLANK;
            r_hex_occ   <= SEG_0;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= lfsr_next(r_lfsr);
            r_hold_cnt  <= w_hold_nxt;
            r_pin_1     <= w_pin_1_nxt;
            r_pin_2     <= w_pin_2_nxt;
            r_pin_valid <= w_pin_valid_nxt;
            r_occupancy <= w_occ_nxt;
            r_lot_full  <= w_full_nxt;
            r_hex_pin1  <= w_hex_pin1_nxt;
            r_hex_pin2  <= w_hex_pin2_nxt;
            r_hex_occ   <= w_hex_occ_nxt;
        end
    end

    assign pin_1     = r_pin_1;
    assign pin_2     = r_pin_2;
    assign pin_valid = r_pin_valid;
    assign lot_full  = r_lot_full;
    assign occupancy = r_occupancy;
    assign HEX_PIN1  = r_hex_pin1;
    assign HEX_PIN2  = r_hex_pin2;
    assign HEX_OCC   = r_hex_occ;

endmodule

// File: doc/parking_ticket_issuer.md
# parking_ticket_issuer

Entrance-kiosk block that issues the per-visit gate PIN the parking gate controller checks. A driver presses the ticket button; the block draws a pseudo-random pair of 2-bit PIN digits, shows them on two 7-segment digits, and drives them to the gate with a valid flag until the gate acknowledges entry or the offer times out. It also tracks lot occupancy from gate acknowledgements and the exit sensor, and refuses tickets when the lot is full.

## Interface
Parameters:
- CAPACITY, 8 — lot size; legal range 1..9.
- HOLD_CYCLES, 500_000_000 — number of clk cycles a ticket stays valid without an ack (10 s at 50 MHz).
- LFSR_SEED, 8'hA5 — reset value of the PIN LFSR; must be nonzero.

Ports (clock and reset first):
- clk  in  1  system clock, 50 MHz (CLOCK_50 at top level).
- reset_n  in  1  synchronous, active-low reset.
- ticket_req_n  in  1  raw push button, active low, asynchronous to clk.
- sensor_exit  in  1  exit-lane car sensor, active high, asynchronous to clk.
- ticket_ack  in  1  one-cycle pulse from the gate controller meaning the car entered on this ticket.
- pin_1  out  2  first PIN digit to the gate.
- pin_2  out  2  second PIN digit to the gate.
- pin_valid  out  1  pin_1/pin_2 hold a live ticket.
- lot_full  out  1  occupancy == CAPACITY.
- occupancy  out  4  cars currently in the lot.
- HEX_PIN1, HEX_PIN2, HEX_OCC  out  7 each  segment drives, active low, bit order {g,f,e,d,c,b,a}.

## Operation
- Input conditioning: ticket_req_n and sensor_exit each pass through a 2-flop synchronizer. The synchronized request is inverted and rising-edge detected into req_pulse. The synchronized sensor is rising-edge detected into exit_pulse. Each pulse is one cycle long.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, steps every cycle, never all-zero.
- FSM states:
  - IDLE: req_pulse && !lot_full → ISSUE. req_pulse && lot_full is dropped.
  - ISSUE (1 cycle): latch pin_1 = lfsr[1:0], pin_2 = lfsr[3:2]; set pin_valid; clear the hold counter; go to WAIT_ACK.
  - WAIT_ACK: ticket_ack → occupancy+1, clear pin_valid, go to IDLE. Hold counter reaching HOLD_CYCLES-1 → clear pin_valid, go to IDLE. req_pulse is ignored.
- Occupancy:
  - increments on an accepted ticket_ack and decrements on exit_pulse.
  - saturates at CAPACITY and at 0.
  - an ack and an exit_pulse in the same cycle leave it unchanged.
  - ticket_ack outside WAIT_ACK is ignored.
- Displays:
  - HEX_PIN1 and HEX_PIN2 show the pin digits 0..3 while pin_valid is high, otherwise blank (7'h7F).
  - HEX_OCC shows occupancy 0..9, or 'F' (7'h0E) when lot_full.
- Reset values: state IDLE, pin_1 = pin_2 = 0, pin_valid = 0, occupancy = 0, lot_full = 0, HEX_PIN1 = HEX_PIN2 = 7'h7F, HEX_OCC = 7'h40 ('0'), synchronizers cleared, LFSR = LFSR_SEED.
- A reset asserted mid-ticket discards the ticket; pin_valid is 0 on the next edge.

## Timing
- All outputs are registered.
- Request latency: button edge at the synchronizer input → pin_valid high 4 cycles later (2 synchronizer stages, 1 edge detect, 1 ISSUE).
- pin_1/pin_2 are stable for the whole time pin_valid is high.
- ticket_ack sampled in cycle N → pin_valid = 0 and the occupancy update visible at N+1.
- Timeout: pin_valid stays high for exactly HOLD_CYCLES cycles after it rises unless acked earlier.
- lot_full is updated in the same cycle as occupancy.
- The hold counter is 29 bits, sized for the default HOLD_CYCLES.

## Structure
- The package parking_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT_ACK);
  - the 7-segment constants for 0-9, 'F' and blank;
  - a function seg7(input [3:0]) returning an active-low pattern.
- Sub-module sync_edge: 2-flop synchronizer plus rising-edge detector, parameterised on polarity. It is instantiated twice, for the request and exit inputs.

## Test plan
- Reset then request: release reset_n, pulse ticket_req_n low for 10 cycles. Required: pin_valid = 1 four cycles after the edge; pins equal bits [1:0] and [3:2] of the LFSR value captured in ISSUE; HEX_PIN digits match.
- Ack path: after a ticket, pulse ticket_ack. Required: pin_valid = 0 and occupancy = 1 next cycle; HEX_OCC = 7'h79 ('1').
- Timeout: use HOLD_CYCLES = 20 and send no ack. Required: pin_valid high exactly 20 cycles, occupancy unchanged, HEX_PIN blank afterwards.
- Full lot: use CAPACITY = 2 and issue/ack twice. Required: lot_full = 1, HEX_OCC = 7'h0E; a third request gives pin_valid held at 0.
- Simultaneous events: with occupancy = 1, ticket_ack and exit_pulse land in the same cycle. Required: occupancy stays 1. Separately, exit_pulse at occupancy 0 gives occupancy stays 0.
- Reset mid-ticket: assert reset_n = 0 while in WAIT_ACK. Required: on the next edge pin_valid = 0, occupancy = 0, all HEX outputs at their reset values.
